// File: rtl/ysyx_24090003_mem_arbiter.sv
// Arbitrates instruction fetch and load/store onto one memory port, one transaction in flight.
// Tie-breaking: fixed load/store priority by default; round-robin when YSYX_24090003_ARB_RR_EN is defined.
module ysyx_24090003_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                cpu_clk,
  input  logic                cpu_rs,
  // fetch port
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_resp_data,
  // load/store port
  input  logic                ls_req_valid,
  input  logic                ls_req_wen,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wmask,
  output logic                ls_req_ready,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_resp_data,
  // shared memory port
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_wen,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data
);
  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_t;

  state_t              state;
  owner_t              owner;
  logic                lat_wen;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [MASK_W-1:0]   lat_wmask;

  logic idle;
  logic ls_first;
  logic grant_if;
  logic grant_ls;
  logic resp_fire;

`ifdef YSYX_24090003_ARB_RR_EN
  owner_t last_served;
  // Load/store wins a tie only when fetch was served last.
  assign ls_first = (last_served == OWN_IF);
`else
  assign ls_first = 1'b1;
`endif

  // Gating with cpu_rs keeps the readies low while reset is held even though the FSM already sits in IDLE.
  assign idle     = (state == ST_IDLE) && !cpu_rs;
  assign grant_ls = idle && ls_req_valid && (ls_first || !if_req_valid);
  assign grant_if = idle && if_req_valid && !grant_ls;

  assign if_req_ready = grant_if;
  assign ls_req_ready = grant_ls;

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge cpu_clk or posedge cpu_rs) begin
    if (cpu_rs) begin
      state     <= ST_IDLE;
      owner     <= OWN_IF;
      lat_wen   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wmask <= '0;
`ifdef YSYX_24090003_ARB_RR_EN
      last_served <= OWN_IF;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_ls) begin
            state     <= ST_REQ;
            owner     <= OWN_LS;
            lat_wen   <= ls_req_wen;
            lat_addr  <= ls_req_addr;
            lat_wdata <= ls_req_wdata;
            lat_wmask <= ls_req_wmask;
`ifdef YSYX_24090003_ARB_RR_EN
            last_served <= OWN_LS;
`endif
          end else if (grant_if) begin
            state     <= ST_REQ;
            owner     <= OWN_IF;
            lat_wen   <= 1'b0;
            lat_addr  <= if_req_addr;
            lat_wdata <= '0;
            lat_wmask <= '1;
`ifdef YSYX_24090003_ARB_RR_EN
            last_served <= OWN_IF;
`endif
          end
        end
        ST_REQ:  if (mem_req_ready)  state <= ST_RESP;
        ST_RESP: if (mem_resp_valid) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Request fields come only from the latched copy and read as zero whenever no request is presented.
  assign mem_req_valid = (state == ST_REQ);
  assign mem_req_wen   = mem_req_valid & lat_wen;
  assign mem_req_addr  = {ADDR_W{mem_req_valid}} & lat_addr;
  assign mem_req_wdata = {DATA_W{mem_req_valid}} & lat_wdata;
  assign mem_req_wmask = {MASK_W{mem_req_valid}} & lat_wmask;

  assign resp_fire     = (state == ST_RESP) && mem_resp_valid;
  assign if_resp_valid = resp_fire && (owner == OWN_IF);
  assign ls_resp_valid = resp_fire && (owner == OWN_LS);
  assign if_resp_data  = {DATA_W{if_resp_valid}} & mem_resp_data;
  assign ls_resp_data  = {DATA_W{ls_resp_valid}} & mem_resp_data;

endmodule

// File: tb/tb_ysyx_24090003_mem_arbiter.sv
// Directed bench for ysyx_24090003_mem_arbiter: expected memory requests and responses are queued
// at issue time and compared by a monitor whenever the DUT presents them.
module tb_ysyx_24090003_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;
`ifdef YSYX_24090003_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
  } mreq_t;

  typedef struct {
    logic          is_ls;
    logic          chk_data;
    logic [DW-1:0] data;
  } resp_t;

  logic          cpu_clk;
  logic          cpu_rs;
  logic          if_req_valid;
  logic [AW-1:0] if_req_addr;
  logic          if_req_ready;
  logic          if_resp_valid;
  logic [DW-1:0] if_resp_data;
  logic          ls_req_valid;
  logic          ls_req_wen;
  logic [AW-1:0] ls_req_addr;
  logic [DW-1:0] ls_req_wdata;
  logic [MW-1:0] ls_req_wmask;
  logic          ls_req_ready;
  logic          ls_resp_valid;
  logic [DW-1:0] ls_resp_data;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic          mem_req_wen;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic [MW-1:0] mem_req_wmask;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_data;

  mreq_t exp_mreq[$];
  resp_t exp_resp[$];
  int    n_checks = 0;
  int    n_err    = 0;

  ysyx_24090003_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .cpu_clk        (cpu_clk),
    .cpu_rs         (cpu_rs),
    .if_req_valid   (if_req_valid),
    .if_req_addr    (if_req_addr),
    .if_req_ready   (if_req_ready),
    .if_resp_valid  (if_resp_valid),
    .if_resp_data   (if_resp_data),
    .ls_req_valid   (ls_req_valid),
    .ls_req_wen     (ls_req_wen),
    .ls_req_addr    (ls_req_addr),
    .ls_req_wdata   (ls_req_wdata),
    .ls_req_wmask   (ls_req_wmask),
    .ls_req_ready   (ls_req_ready),
    .ls_resp_valid  (ls_resp_valid),
    .ls_resp_data   (ls_resp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_wen    (mem_req_wen),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT-presented memory handshakes and responses against the queues.
  always @(negedge cpu_clk) begin : monitor
    mreq_t m;
    resp_t r;
    if (mem_req_valid && mem_req_ready) begin
      if (exp_mreq.size() == 0) begin
        check("mem_req_unexpected", mem_req_addr, 32'd0);
      end else begin
        m = exp_mreq.pop_front();
        check("mem_req_addr", mem_req_addr, m.addr);
        check("mem_req_ctl", 32'({mem_req_wen, mem_req_wmask}), 32'({m.wen, m.wmask}));
        if (m.wen) check("mem_req_wdata", mem_req_wdata, m.wdata);
      end
    end
    if (if_resp_valid || ls_resp_valid) begin
      if (if_resp_valid && ls_resp_valid) begin
        check("resp_both_ports", 32'({if_resp_valid, ls_resp_valid}), 32'd0);
      end else if (exp_resp.size() == 0) begin
        check("resp_unexpected", 32'({if_resp_valid, ls_resp_valid}), 32'd0);
      end else begin
        r = exp_resp.pop_front();
        check("resp_port", 32'(ls_resp_valid), 32'(r.is_ls));
        if (r.chk_data) check("resp_data", ls_resp_valid ? ls_resp_data : if_resp_data, r.data);
      end
    end
  end

  function automatic mreq_t make_req(input logic wen, input logic [AW-1:0] addr,
                                     input logic [DW-1:0] wdata, input logic [MW-1:0] wmask);
    mreq_t m;
    m.wen   = wen;
    m.addr  = addr;
    m.wdata = wdata;
    m.wmask = wmask;
    return m;
  endfunction

  task automatic expect_txn(input mreq_t m, input logic is_ls, input logic chk_data,
                            input logic [DW-1:0] rdata);
    resp_t r;
    r.is_ls    = is_ls;
    r.chk_data = chk_data;
    r.data     = rdata;
    exp_mreq.push_back(m);
    exp_resp.push_back(r);
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid, mem_req_valid,
                mem_req_wen, |mem_req_addr, |mem_req_wdata, |mem_req_wmask,
                |if_resp_data, |ls_resp_data});
  endfunction

  // Called in an IDLE cycle with requests driven; checks who is granted, then clocks the grant.
  task automatic expect_grant(input logic ls_wins);
    #1;
    check("grant", 32'({if_req_ready, ls_req_ready}), ls_wins ? 32'd1 : 32'd2);
    check("mem_idle_zero", 32'({mem_req_valid, mem_req_wen, |mem_req_addr, |mem_req_wdata,
                                 |mem_req_wmask}), 32'd0);
    tick();
  endtask

  // Runs the REQ and RESP phases of an accepted transaction from the memory side.
  task automatic serve_mem(input mreq_t m, input logic is_ls, input int stall, input int delay,
                           input logic [DW-1:0] rdata);
    #1;
    check("req_state", 32'({mem_req_valid, if_req_ready, ls_req_ready}), 32'd4);
    for (int i = 0; i < stall; i++) begin
      mem_req_ready = 1'b0;
      #1;
      check("req_stable_addr", mem_req_addr, m.addr);
      check("req_stable_ctl", 32'({mem_req_valid, mem_req_wen, mem_req_wmask}),
            32'({1'b1, m.wen, m.wmask}));
      if (m.wen) check("req_stable_wdata", mem_req_wdata, m.wdata);
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < delay; i++) begin
      #1;
      check("resp_wait", 32'({if_resp_valid, ls_resp_valid, if_req_ready, ls_req_ready,
                              mem_req_valid}), 32'd0);
      tick();
    end
    mem_resp_valid = 1'b1;
    mem_resp_data  = rdata;
    #1;
    check("resp_owner_valid", 32'({if_resp_valid, ls_resp_valid}), is_ls ? 32'd1 : 32'd2);
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
  endtask

  task automatic clear_inputs();
    if_req_valid   = 1'b0;
    if_req_addr    = '0;
    ls_req_valid   = 1'b0;
    ls_req_wen     = 1'b0;
    ls_req_addr    = '0;
    ls_req_wdata   = '0;
    ls_req_wmask   = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
  endtask

  initial begin : stim
    mreq_t m;
    logic  ls_w;

    // Reset holds every output low even with all inputs active.
    clear_inputs();
    cpu_rs         = 1'b1;
    if_req_valid   = 1'b1;
    if_req_addr    = 32'h8000_0000;
    ls_req_valid   = 1'b1;
    ls_req_addr    = 32'h8000_1000;
    ls_req_wmask   = 4'hF;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hFFFF_FFFF;
    #3;
    check("reset_outputs_async", all_outputs(), 32'd0);
    tick();
    tick();
    check("reset_outputs_held", all_outputs(), 32'd0);

    // Release, then a fetch is accepted in the very first IDLE cycle.
    clear_inputs();
    cpu_rs       = 1'b0;
    if_req_valid = 1'b1;
    if_req_addr  = 32'h8000_0000;
    m = make_req(1'b0, 32'h8000_0000, '0, 4'hF);
    expect_txn(m, 1'b0, 1'b1, 32'h0000_0413);
    expect_grant(1'b0);
    if_req_valid = 1'b0;
    if_req_addr  = 32'h1234_5678;
    serve_mem(m, 1'b0, 0, 0, 32'h0000_0413);

    // Store held off by memory for 3 cycles; requester payload changes after acceptance.
    ls_req_valid = 1'b1;
    ls_req_wen   = 1'b1;
    ls_req_addr  = 32'h8000_1000;
    ls_req_wdata = 32'hDEAD_BEEF;
    ls_req_wmask = 4'h3;
    m = make_req(1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'h3);
    expect_txn(m, 1'b1, 1'b0, 32'h5555_AAAA);
    expect_grant(1'b1);
    ls_req_valid = 1'b0;
    ls_req_addr  = 32'h0000_0004;
    ls_req_wdata = 32'h0BAD_F00D;
    ls_req_wmask = 4'hC;
    serve_mem(m, 1'b1, 3, 1, 32'h5555_AAAA);
    ls_req_wen = 1'b0;

    // Spurious memory response while IDLE with no requester.
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hBAD0_0001;
    #1;
    check("spurious_idle", 32'({if_resp_valid, ls_resp_valid, mem_req_valid}), 32'd0);
    tick();
    mem_resp_valid = 1'b0;

    // Spurious memory response while waiting in REQ must not advance the FSM.
    if_req_valid = 1'b1;
    if_req_addr  = 32'h8000_0004;
    m = make_req(1'b0, 32'h8000_0004, '0, 4'hF);
    expect_txn(m, 1'b0, 1'b1, 32'h0010_0093);
    expect_grant(1'b0);
    if_req_valid   = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hBAD0_0002;
    tick();
    mem_resp_valid = 1'b0;
    serve_mem(m, 1'b0, 1, 0, 32'h0010_0093);

    // Both requesters held valid across 4 transactions; last served here is fetch.
    if_req_valid = 1'b1;
    if_req_addr  = 32'h8000_0010;
    ls_req_valid = 1'b1;
    ls_req_wen   = 1'b0;
    ls_req_addr  = 32'h8000_2000;
    ls_req_wmask = 4'hF;
    for (int i = 0; i < 4; i++) begin
      ls_w = RR ? (i % 2 == 0) : 1'b1;
      m = ls_w ? make_req(1'b0, 32'h8000_2000, '0, 4'hF) : make_req(1'b0, 32'h8000_0010, '0, 4'hF);
      expect_txn(m, ls_w, 1'b1, 32'h1000_0000 + 32'(i));
      expect_grant(ls_w);
      serve_mem(m, ls_w, 0, 0, 32'h1000_0000 + 32'(i));
    end
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;

    // Reset pulsed during RESP aborts the fetch; the late memory response is ignored.
    if_req_valid = 1'b1;
    if_req_addr  = 32'h8000_0020;
    m = make_req(1'b0, 32'h8000_0020, '0, 4'hF);
    exp_mreq.push_back(m);
    expect_grant(1'b0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    cpu_rs         = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hBAD0_0003;
    #1;
    check("reset_mid_resp_outputs", all_outputs(), 32'd0);
    cpu_rs       = 1'b0;
    if_req_valid = 1'b0;
    #1;
    check("after_abort", 32'({if_resp_valid, ls_resp_valid, mem_req_valid}), 32'd0);
    tick();
    mem_resp_valid = 1'b0;

    // First tie after reset goes to load/store in either build; then fetch is served normally.
    if_req_valid = 1'b1;
    if_req_addr  = 32'h8000_0024;
    ls_req_valid = 1'b1;
    ls_req_addr  = 32'h8000_3000;
    ls_req_wmask = 4'h1;
    m = make_req(1'b0, 32'h8000_3000, '0, 4'h1);
    expect_txn(m, 1'b1, 1'b1, 32'h2222_0001);
    expect_grant(1'b1);
    ls_req_valid = 1'b0;
    serve_mem(m, 1'b1, 0, 0, 32'h2222_0001);
    m = make_req(1'b0, 32'h8000_0024, '0, 4'hF);
    expect_txn(m, 1'b0, 1'b1, 32'h2222_0002);
    expect_grant(1'b0);
    if_req_valid = 1'b0;
    serve_mem(m, 1'b0, 2, 2, 32'h2222_0002);

    // Tie with fetch served last: round-robin grants load/store, fixed priority also load/store.
    // Then a tie with load/store served last separates the two policies.
    if_req_valid = 1'b1;
    if_req_addr  = 32'h8000_0028;
    ls_req_valid = 1'b1;
    ls_req_addr  = 32'h8000_4000;
    ls_req_wmask = 4'hF;
    m = make_req(1'b0, 32'h8000_4000, '0, 4'hF);
    expect_txn(m, 1'b1, 1'b1, 32'h3333_0001);
    expect_grant(1'b1);
    serve_mem(m, 1'b1, 0, 0, 32'h3333_0001);
    ls_w = RR ? 1'b0 : 1'b1;
    m = ls_w ? make_req(1'b0, 32'h8000_4000, '0, 4'hF) : make_req(1'b0, 32'h8000_0028, '0, 4'hF);
    expect_txn(m, ls_w, 1'b1, 32'h3333_0002);
    expect_grant(ls_w);
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    serve_mem(m, ls_w, 0, 0, 32'h3333_0002);

    tick();
    check("mem_req_queue_drained", 32'(exp_mreq.size()), 32'd0);
    check("resp_queue_drained", 32'(exp_resp.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_24090003_mem_arbiter.md
YSYX_24090003_MEM_ARBITER -- requirements
Module: ysyx_24090003_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width of all request ports SHALL be ADDR_W.
REQ-002 Parameter DATA_W, 32, data width of all data ports SHALL be DATA_W; mask width SHALL be DATA_W/8.
REQ-003 cpu_clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 cpu_rs  in  1  reset; asynchronous, active-high.
REQ-005 if_req_valid  in  1  fetch request; if_req_addr  in  ADDR_W  fetch address (PC).
REQ-006 if_req_ready  out  1  fetch request accepted this cycle.
REQ-007 if_resp_valid  out  1  fetch data valid pulse; if_resp_data  out  DATA_W  instruction word.
REQ-008 ls_req_valid  in  1; ls_req_wen  in  1 (1=store); ls_req_addr  in  ADDR_W; ls_req_wdata  in  DATA_W; ls_req_wmask  in  DATA_W/8.
REQ-009 ls_req_ready  out  1; ls_resp_valid  out  1; ls_resp_data  out  DATA_W (load data; don't-care for stores).
REQ-010 mem_req_valid  out  1; mem_req_ready  in  1; mem_req_wen  out  1; mem_req_addr  out  ADDR_W; mem_req_wdata  out  DATA_W; mem_req_wmask  out  DATA_W/8.
REQ-011 mem_resp_valid  in  1; mem_resp_data  in  DATA_W  single shared memory port response.

Function
REQ-012 FSM states SHALL be IDLE, REQ, RESP; exactly one transaction outstanding at any time.
REQ-013 IDLE: if any requester valid, arbiter SHALL assert the winner's ready combinationally in that cycle, latch winner's addr/wen/wdata/wmask and owner id, and go to REQ next cycle; loser's ready SHALL be 0.
REQ-014 Fetch requests SHALL be latched with wen=0, wmask=all ones.
REQ-015 REQ: mem_req_valid=1 driven from latched fields only; on mem_req_valid&&mem_req_ready go to RESP; latched fields SHALL stay stable while waiting.
REQ-016 RESP: on mem_resp_valid, owner's resp_valid SHALL be 1 in that same cycle with resp_data=mem_resp_data (combinational pass-through); FSM returns to IDLE next cycle.
REQ-017 Non-owner resp_valid SHALL never assert; mem_resp_valid outside RESP SHALL be ignored.
REQ-018 Both req_ready outputs SHALL be 0 in REQ and RESP; a new request is accepted no earlier than the cycle after the response (minimum 3-cycle turnaround per transaction).
REQ-019 Requesters SHALL hold valid and payload until ready; arbiter does not buffer unaccepted requests.
REQ-020 Simultaneous if/ls valid in IDLE SHALL resolve per REQ-025/REQ-026; single valid SHALL always win regardless of policy.
REQ-021 mem_req_addr/wdata/wmask/wen SHALL be 0 when mem_req_valid=0.

Reset
REQ-022 While cpu_rs=1, FSM SHALL be IDLE, owner/latched fields 0, and all outputs 0, independent of cpu_clk.
REQ-023 Reset asserted in REQ or RESP SHALL abort the transaction; no resp_valid SHALL be emitted for it after reset release.
REQ-024 After release, first request SHALL be accepted in the first IDLE cycle with a valid input.

Configuration
REQ-025 Macro YSYX_24090003_ARB_RR_EN defined: round-robin; on simultaneous requests, grant the requester not served last; last-served bit resets to "fetch", so first tie goes to load/store.
REQ-026 Macro undefined: fixed priority, load/store SHALL always win ties over fetch; no last-served state exists.

Verification
REQ-027 Reset release, if_req_valid=1 addr 0x80000000, mem_req_ready=1, mem_resp_valid 1 cycle later data 0x00000413 -> if_req_ready cycle 0, mem_req_valid cycle 1 addr 0x80000000 wmask 0xF, if_resp_valid+data 0x00000413 cycle 2.
REQ-028 Store: ls wen=1 addr 0x80001000 wdata 0xDEADBEEF wmask 0x3, mem_req_ready held 0 for 3 cycles -> mem_req fields stable 3 cycles, ls_resp_valid only on mem_resp_valid, if_resp_valid stays 0.
REQ-029 if and ls valid together for 4 back-to-back transactions -> without macro all 4 grant ls while held; with macro grants alternate ls,if,ls,if.
REQ-030 cpu_rs pulsed mid-RESP, then mem_resp_valid=1 -> no resp_valid on either port; mem_req_valid 0; next if request served normally.
REQ-031 Spurious mem_resp_valid=1 in IDLE and REQ -> no resp_valid output, FSM state unchanged.
